bin_bcd_sched: RTL
==================

BIN_BCD_SCHED -- requirements
Module: bin_bcd_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one converter (2..8).
REQ-002 SHALL have parameter W, default 32, binary input width.
REQ-003 SHALL have parameter DIGITS, default 10, number of BCD output digits (10 covers 2^32-1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ, per-requester request valid.
REQ-007 SHALL have port req_data, input, NREQ*W, binary operand; requester k in bits [k*W +: W].
REQ-008 SHALL have port req_ready, output, NREQ, one-hot grant/accept strobe.
REQ-009 SHALL have port rsp_valid, output, 1, result available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_bcd, output, 4*DIGITS, packed BCD; digit 0 (units) in bits [3:0].
REQ-012 SHALL have port rsp_id, output, $clog2(NREQ), index of the requester that owns rsp_bcd.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CONV and RESP.
REQ-015 IDLE: if any req_valid is high, SHALL grant exactly one requester k by round-robin, searching from ptr+1 upward with wrap, then go to CONV.
REQ-016 SHALL drive req_ready[k] high only in IDLE, combinationally from req_valid, for exactly the handshake cycle; all other req_ready bits SHALL be 0.
REQ-017 At the handshake, SHALL latch req_data[k], set ptr and rsp_id to k, and clear the BCD accumulator.
REQ-018 CONV: SHALL run W double-dabble iterations, MSB first, one per cycle.
REQ-019 Each iteration SHALL first add 3 to every digit >= 5, then shift {bcd, bin} left by 1.
REQ-020 SHALL use a $clog2(W+1)-bit iteration counter and go to RESP after iteration W.
REQ-021 Latency: handshake in cycle T, CONV in cycles T+1..T+W, rsp_valid high from cycle T+W+1.
REQ-022 RESP: rsp_valid, rsp_bcd and rsp_id SHALL stay stable until rsp_valid && rsp_ready.
REQ-023 On the response handshake, SHALL return to IDLE; the earliest next grant is the following cycle, so throughput is one conversion per W+2 cycles minimum.
REQ-024 Requests SHALL NOT be sticky: a requester that drops req_valid before being granted is not served.
REQ-025 req_valid and req_data changes during CONV or RESP SHALL have no effect.
REQ-026 rsp_bcd SHALL be valid BCD (every digit 0..9) for all W-bit inputs, including 0 and 2^W-1.
REQ-027 Any BCD digits above the width needed for W SHALL read 0.
REQ-028 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 rst_n low SHALL asynchronously force state to IDLE and clear the iteration counter, accumulator and latched operand.
REQ-030 rst_n low SHALL set ptr to NREQ-1, so requester 0 has first priority after reset.
REQ-031 rst_n low SHALL clear rsp_valid, rsp_bcd, rsp_id, busy and req_ready to 0.
REQ-032 Reset asserted during CONV or RESP SHALL drop the conversion in progress; no response for it is ever produced.
REQ-033 Release of rst_n SHALL be synchronised before reaching the FSM; the first grant is possible 2 cycles after release.

Structure
REQ-034 Package bin_bcd_pkg SHALL hold the state enum type and the default values of W, DIGITS and NREQ.
REQ-035 Sub-module bcd_dd_core SHALL contain the iterative double-dabble datapath, with load/step control from the FSM.
REQ-036 The arbiter and FSM SHALL stay in bin_bcd_sched.

Verification
REQ-037 Requester 0 sends 0 -> rsp_bcd 0x0000000000, rsp_id 0, rsp_valid in cycle T+33.
REQ-038 Requester 2 sends 12345678 -> rsp_bcd 0x0012345678, rsp_id 2; 4294967295 -> 0x4294967295.
REQ-039 All four requesters hold valid continuously from reset -> grant order 0,1,2,3,0, with rsp_ready tied high.
REQ-040 rsp_ready held low 10 cycles in RESP -> rsp_bcd and rsp_id stable; no req_ready asserted; busy stays 1.
REQ-041 rst_n pulsed low at CONV iteration 15 -> all outputs 0 immediately and no response; a new request of 99 -> 0x0000000099.
REQ-042 Requester 1 pulses valid for one cycle while busy -> never granted; random 10k operands match a reference model.

Source files
------------

// File: rtl/bin_bcd_pkg.sv
// Shared types and default sizing for the round-robin binary-to-BCD converter.
package bin_bcd_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 32;
    localparam int DIGITS_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble datapath: one add-3/shift iteration per step, MSB first.
module bcd_dd_core
    import bin_bcd_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [W-1:0]          load_data,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [W-1:0]        bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;

    // Add 3 to every digit of 5 or more so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load clears the accumulator; each step shifts {bcd, bin} left by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else if (load) begin
            bin_q <= load_data;
            bcd_q <= '0;
        end else if (step) begin
            bcd_q <= {bcd_adj[4*DIGITS-2:0], bin_q[W-1]};
            bin_q <= {bin_q[W-2:0], 1'b0};
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/bin_bcd_sched.sv
// Round-robin front end sharing one double-dabble converter among NREQ requesters.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for any req_valid; grants one requester per cycle
//   ST_CONV | W double-dabble iterations on the latched operand
//   ST_RESP | result held on rsp_* until the consumer accepts it
module bin_bcd_sched
    import bin_bcd_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int W      = W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [4*DIGITS-1:0]       rsp_bcd,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W+1);

    logic [1:0]     rst_sync;
    logic           rst_int_n;
    logic           fsm_live;
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  iter_cnt;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   grant_data;
    logic           grant_fire;

    // Reset asserts immediately, releases two clock edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Separate copy of the synchronised release so the reset net never feeds logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_live <= 1'b0;
        end else begin
            fsm_live <= rst_sync[0];
        end
    end

    // Round-robin search starting just after the previous winner, with wrap.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                grant_data = req_data[k*W +: W];
            end
        end
    end

    assign grant_fire = (state == ST_IDLE) && fsm_live && grant_any;

    // One-hot accept strobe, live only during the IDLE handshake cycle.
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer: grant, W conversion steps on a down-counter, then hold the result.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= ST_IDLE;
            ptr       <= IDW'(NREQ-1);
            iter_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        state    <= ST_CONV;
                        ptr      <= grant_idx;
                        rsp_id   <= grant_idx;
                        iter_cnt <= CW'(W);
                        busy     <= 1'b1;
                    end
                end
                ST_CONV: begin
                    iter_cnt <= iter_cnt - CW'(1);
                    if (iter_cnt == CW'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    iter_cnt  <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    bcd_dd_core #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .load      (grant_fire),
        .step      (state == ST_CONV),
        .load_data (grant_data),
        .bcd       (rsp_bcd)
    );

endmodule
